acc_normalizer: RTL and testbench



---
 rtl/acc_normalizer.sv | 121 ++++++++++++
 tb/tb_acc_normalizer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/acc_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : acc_normalizer
// Purpose  : Sequential normalizer. Compresses a 34-bit unsigned accumulator
//            value into an 8-bit mantissa and a 5-bit shift count so that
//            (out << n_shift) reconstructs the value, truncated toward zero.
//            The shift is found one binary stage per cycle (16, 8, 4, 2, 1).
// Ports    : clk        - clock, rising edge
//            rst        - synchronous active-high reset
//            in_valid   - in_data is valid
//            in_ready   - block accepts input (IDLE only)
//            in_data    - 34-bit unsigned accumulator value
//            out_valid  - result valid, held until consumed
//            out_ready  - downstream accepts the result
//            out        - 8-bit mantissa (registered)
//            n_shift    - 5-bit shift count (registered)
//            error      - inexact flag: a nonzero bit was discarded
// Revision : 1.0 - initial release
// ============================================================================
module acc_normalizer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [33:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out,
   output logic [4:0]  n_shift,
   output logic        error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] LAST_STAGE = 3'd4;

   state_t      state;
   logic [33:0] x;
   logic [4:0]  n;
   logic        sticky;
   logic [2:0]  stage;

   // One stage of the greedy decomposition of (msb - 7)
   logic [4:0]  step;
   logic [33:0] low_mask;
   logic        take;
   logic [33:0] x_next;
   logic [4:0]  n_next;
   logic        sticky_next;

   always_comb begin
      step        = 5'd16 >> stage;
      low_mask    = (34'd1 << step) - 34'd1;
      // x >= 2^(7+step) exactly when some bit at or above 7+step is set
      take        = (x >> (step + 5'd7)) != 34'd0;
      x_next      = x;
      n_next      = n;
      sticky_next = sticky;
      if (take) begin
         x_next      = x >> step;
         n_next      = n + step;
         sticky_next = sticky | ((x & low_mask) != 34'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         x       <= '0;
         n       <= '0;
         sticky  <= 1'b0;
         stage   <= '0;
         out     <= '0;
         n_shift <= '0;
         error   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x      <= in_data;
                  n      <= '0;
                  sticky <= 1'b0;
                  stage  <= '0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               x      <= x_next;
               n      <= n_next;
               sticky <= sticky_next;
               stage  <= stage + 3'd1;
               if (stage == LAST_STAGE) begin
                  // After the 1-step stage x_next < 256, so no bits are lost here
                  out     <= x_next[7:0];
                  n_shift <= n_next;
                  error   <= sticky_next;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Handshake flags decode from the state register only
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_acc_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_normalizer
// Purpose  : Self-checking bench for acc_normalizer. Directed corner values,
//            backpressure, mid-operation reset and a random sweep, all
//            compared against an arithmetic reference of the result rules.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_normalizer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [33:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out;
   logic [4:0]  n_shift;
   logic        error;

   int tests;
   int failures;

   acc_normalizer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .n_shift   (n_shift),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("%s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Result rules: shift = max(0, msb-7), mantissa = value >> shift,
   // inexact when any discarded bit is set.
   function automatic void ref_model(input logic [33:0] d, output logic [7:0] o,
                                     output logic [4:0] s, output logic e);
      longint unsigned v;
      int msb;
      int sh;
      v   = 64'(d);
      msb = -1;
      for (int i = 0; i < 34; i++) if (d[i]) msb = i;
      sh  = (msb > 7) ? msb - 7 : 0;
      o   = 8'(v >> sh);
      s   = 5'(sh);
      e   = (v & ((64'd1 << sh) - 64'd1)) != 64'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full transaction: accept, wait for result, optionally stall the
   // consumer while poking new inputs, then consume.
   task automatic do_txn(input logic [33:0] d, input int hold);
      logic [7:0] eo;
      logic [4:0] es;
      logic       ee;
      int         lat;
      longint unsigned recon;
      ref_model(d, eo, es, ee);
      check("pre_in_ready", 64'(in_ready), 64'd1);
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("latency", 64'(lat), 64'd5);
      check("out", 64'(out), 64'(eo));
      check("n_shift", 64'(n_shift), 64'(es));
      check("error", 64'(error), 64'(ee));
      check("done_in_ready", 64'(in_ready), 64'd0);
      recon = 64'(out) << n_shift;
      check("recon_vs_error", 64'(recon == 64'(d)), 64'(!error));
      for (int i = 0; i < hold; i++) begin
         in_valid = (i % 2) == 0;
         in_data  = d ^ 34'({$urandom, 2'b01});
         tick();
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out", 64'(out), 64'(eo));
         check("bp_n_shift", 64'(n_shift), 64'(es));
         check("bp_error", 64'(error), 64'(ee));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_out_valid", 64'(out_valid), 64'd0);
      check("post_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [33:0] rd;
      int          w;
      tests     = 0;
      failures  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out", 64'(out), 64'd0);
      check("rst_n_shift", 64'(n_shift), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      rst = 1'b0;
      tick();

      // Directed corner values
      do_txn(34'h0A5, 0);
      do_txn(34'h100, 0);
      do_txn(34'h101, 0);
      do_txn(34'h0FF, 0);
      do_txn(34'h3FFFFFFFF, 0);
      do_txn(34'h200000000, 0);
      do_txn(34'h0, 0);
      do_txn(34'h12C00, 0);
      // Explicit spec values for the mid-range exact case
      check("mid_out", 64'(out), 64'h96);
      check("mid_n_shift", 64'(n_shift), 64'd9);

      // Backpressure: result held for 10 cycles while new data is ignored
      do_txn(34'h1234567, 10);
      tick();
      check("bp_after_idle", 64'(in_ready), 64'd1);
      check("bp_after_no_valid", 64'(out_valid), 64'd0);

      // Reset during BUSY stage 2
      in_data  = 34'h3FFFFFFFF;
      in_valid = 1'b1;
      tick();              // accept
      in_valid = 1'b0;
      tick();              // stage 0
      tick();              // stage 1
      rst = 1'b1;
      tick();              // reset edge lands where stage 2 would run
      rst = 1'b0;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out", 64'(out), 64'd0);
      check("midrst_n_shift", 64'(n_shift), 64'd0);
      check("midrst_error", 64'(error), 64'd0);
      tick();
      check("midrst_stay_idle", 64'(out_valid), 64'd0);
      do_txn(34'h101, 0);
      check("after_rst_out", 64'(out), 64'h80);
      check("after_rst_n_shift", 64'(n_shift), 64'd1);
      check("after_rst_error", 64'(error), 64'd1);

      // Random sweep: random widths plus exactly-representable values
      for (int i = 0; i < 40; i++) begin
         w  = $urandom_range(34, 1);
         rd = 34'({$urandom, $urandom}) & 34'((64'd1 << w) - 64'd1);
         do_txn(rd, (i % 8 == 0) ? 2 : 0);
      end
      for (int i = 0; i < 15; i++) begin
         rd = 34'(64'($urandom_range(255, 0)) << $urandom_range(26, 0));
         do_txn(rd, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

   // Global watchdog so the bench always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation timeout");
   end

endmodule
`default_nettype wire
